// File: rtl/mult_ctrl_pkg.sv
// Shared types for the shift-add multiplier controller: the FSM state encoding
// and the default number of multiplier bits.
package mult_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEFAULT_N = 4;

endpackage

// File: rtl/mult_controller_if.sv
// Controller <-> datapath/requester bundle for the shift-add multiplier.
interface mult_controller_if;

  // Handshake: adx is a level start request, sampled only while the controller
  // is idle. Once accepted, the operation runs to completion regardless of adx.
  // The controller then raises done for one cycle, or holds it while adx stays
  // high when MULT_CTRL_DONE_HOLD_EN is defined. m is the datapath multiplier
  // LSB and is consulted only in ADD. sh and add are single-cycle datapath
  // strobes and are mutually exclusive.
  logic adx;
  logic m;
  logic sh;
  logic add;
  logic done;

  modport master (output adx, output m, input sh, input add, input done);
  modport slave  (input adx, input m, output sh, output add, output done);

endinterface

// File: rtl/mult_ctrl_cnt.sv
// Shift counter for the multiplier controller: counts completed shifts from 0
// to N and flags when the next increment reaches N.
module mult_ctrl_cnt
  import mult_ctrl_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int CW = $clog2(N + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

  // The FSM tests this together with inc, so it names the shift that completes N.
  assign last = (cnt == CW'(N - 1));

endmodule

// File: rtl/mult_controller.sv
// Shift-add multiplier controller FSM (IDLE/ADD/SHIFT/DONE).
// Optional MULT_CTRL_DONE_HOLD_EN: hold done while adx stays high.
module mult_controller
  import mult_ctrl_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic               clk_in,
  input  logic               rst_in,
  mult_controller_if.slave   bus,
  output state_t             state
);

  state_t next;
  logic   clr;
  logic   inc;
  logic   last;

  mult_ctrl_cnt #(.N(N)) u_cnt (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clr    (clr),
    .inc    (inc),
    .last   (last)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (bus.adx) next = ADD;
      ADD:     if (bus.m) next = SHIFT;
               else       next = last ? DONE : ADD;
      SHIFT:   next = last ? DONE : ADD;
`ifdef MULT_CTRL_DONE_HOLD_EN
      DONE:    next = bus.adx ? DONE : IDLE;
`else
      DONE:    next = IDLE;
`endif
      default: next = IDLE;
    endcase
  end

  // add/sh in ADD follow m combinationally; everything else decodes from state.
  always_comb begin
    bus.sh   = 1'b0;
    bus.add  = 1'b0;
    bus.done = 1'b0;
    clr      = 1'b0;
    inc      = 1'b0;
    unique case (state)
      IDLE:    clr = bus.adx;
      ADD: begin
        bus.add = bus.m;
        bus.sh  = ~bus.m;
        inc     = ~bus.m;
      end
      SHIFT: begin
        bus.sh = 1'b1;
        inc    = 1'b1;
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_controller.sv
// Self-checking bench for mult_controller: a bit-level datapath model feeds m,
// and an expected-strobe queue derived from the multiplier value is compared every cycle.
module tb_mult_controller;
  import mult_ctrl_pkg::*;

  localparam int N = 4;

  typedef struct {
    string name;
    int    act;
    int    exp;
  } lit_t;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b1;
  logic         load     = 1'b0;
  logic [N-1:0] load_val = '0;
  logic [N-1:0] mreg     = '0;
  state_t       state;

  int checks    = 0;
  int errors    = 0;
  int sh_total  = 0;
  int add_total = 0;

  logic [2:0] exp_q[$];
  lit_t       lit_q[$];

  mult_controller_if bus();

  mult_controller #(.N(N)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus),
    .state  (state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2 rst_n = 1'b0;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish got running want finished");
    $fatal(1);
  end

  // Datapath model: multiplier register shifted right on every sh strobe.
  always @(posedge clk) begin
    if (load)        mreg <= load_val;
    else if (bus.sh) mreg <= mreg >> 1;
  end
  assign bus.m = mreg[0];

  // Scoreboard: one compare per cycle plus any queued literal checks.
  always @(negedge clk) begin
    logic [2:0] act;
    logic [2:0] exp_v;
    lit_t       l;
    act   = {bus.sh, bus.add, bus.done};
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL cycle t=%0t {sh,add,done} got %b want %b", $time, act, exp_v);
    end
    if (bus.sh === 1'b1)  sh_total++;
    if (bus.add === 1'b1) add_total++;
    while (lit_q.size() > 0) begin
      l = lit_q.pop_front();
      checks++;
      if (l.act != l.exp) begin
        errors++;
        $display("FAIL %s got %0d want %0d", l.name, l.act, l.exp);
      end
    end
  end

  // Driver tasks
  task automatic post(input string name, input int act, input int exp_v);
    lit_t l;
    l.name = name;
    l.act  = act;
    l.exp  = exp_v;
    lit_q.push_back(l);
  endtask

  // Per multiplier bit from LSB: a 1 costs add then sh, a 0 costs sh; then done.
  task automatic push_op(input logic [N-1:0] mult);
    for (int i = 0; i < N; i++) begin
      if (mult[i]) exp_q.push_back(3'b010);
      exp_q.push_back(3'b100);
    end
    exp_q.push_back(3'b001);
  endtask

  // Called just after the adx sample edge; lat counts cycles from first strobe to done.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = c - 1;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [N-1:0] mult, input int exp_lat, input int exp_adds);
    int sh0;
    int add0;
    int lat;
    @(posedge clk); #1;
    sh0  = sh_total;
    add0 = add_total;
    exp_q.push_back(3'b000);
    push_op(mult);
    bus.adx  = 1'b1;
    load     = 1'b1;
    load_val = mult;
    @(posedge clk); #1;
    bus.adx = 1'b0;
    load    = 1'b0;
    wait_done(lat);
    post("latency", lat, exp_lat);
    @(posedge clk); #1;
    post("sh_pulses", sh_total - sh0, N);
    post("add_pulses", add_total - add0, exp_adds);
  endtask

  initial begin
    int lat;
    bus.adx = 1'b0;

    // Reset pulse with adx low: outputs stay 0 and the FSM stays idle.
    @(posedge clk); #1;
    post("reset_state", int'(state), int'(IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 post("idle_state", int'(state), int'(IDLE));

    // Directed vectors: multiplier, strobe-to-done latency, add pulse count.
    run_op(4'h0, 4, 0);
    run_op(4'hF, 8, 4);
    run_op(4'h5, 6, 2);
    run_op(4'hA, 6, 2);
    run_op(4'h8, 5, 1);

    // Asynchronous reset during the 3rd strobe cycle abandons the operation.
    @(posedge clk); #1;
    exp_q.push_back(3'b000);
    push_op(4'h0);
    bus.adx  = 1'b1;
    load     = 1'b1;
    load_val = 4'h0;
    @(posedge clk); #1;
    bus.adx = 1'b0;
    load    = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    post("rst_outputs", int'({bus.sh, bus.add, bus.done}), 0);
    post("rst_state", int'(state), int'(IDLE));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    run_op(4'h3, 6, 2);

    // adx held high across the end of an operation.
    @(posedge clk); #1;
    exp_q.push_back(3'b000);
    push_op(4'h6);
`ifdef MULT_CTRL_DONE_HOLD_EN
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b001);
`else
    exp_q.push_back(3'b000);
    push_op(4'h9);
`endif
    bus.adx  = 1'b1;
    load     = 1'b1;
    load_val = 4'h6;
    @(posedge clk); #1;
    load = 1'b0;
    wait_done(lat);
    post("hold_lat1", lat, 6);
`ifdef MULT_CTRL_DONE_HOLD_EN
    @(posedge clk);
    @(posedge clk); #1;
    bus.adx = 1'b0;
    repeat (3) @(posedge clk);
    #1 post("hold_idle", int'(state), int'(IDLE));
`else
    load     = 1'b1;
    load_val = 4'h9;
    @(posedge clk); #1;
    load = 1'b0;
    post("restart_idle", int'(state), int'(IDLE));
    @(posedge clk); #1;
    bus.adx = 1'b0;
    wait_done(lat);
    post("hold_lat2", lat, 6);
    repeat (3) @(posedge clk);
    #1 post("after_hold_state", int'(state), int'(IDLE));
`endif

    repeat (3) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
